// File: rtl/des_key_schedule.sv
// DES key schedule: takes a 64-bit key, applies PC-1 and streams the 16
// round subkeys through PC-2 in encrypt (K1..K16) or decrypt (K16..K1) order.
// The PC-1 result is kept so a restart can replay the same key in either mode.
//
// Handshakes (key_valid/key_ready and subkey_valid/subkey_ready): a transfer
// happens on a rising edge where valid and ready are both high. Once valid is
// raised, the payload holds stable until that transfer.
module des_key_schedule #(
   parameter int OUT_REG = 0,  // 1 = subkey outputs from a pipeline register
   parameter int ROUND_W = 4   // must be 4 (16 rounds)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic [63:0]        key_in,
   input  logic               decrypt,
   input  logic               restart,
   output logic               subkey_valid,
   input  logic               subkey_ready,
   output logic [47:0]        subkey,
   output logic [ROUND_W-1:0] subkey_round,
   output logic               subkey_last,
   output logic               busy
);

   // FIPS 46-3 tables, 1-based bit numbers (bit n lives at vector index W-n)
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GEN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 1; i <= 56; i++) begin
         r[6'(56 - i)] = k[6'(64 - PC1_TAB[6'(i - 1)])];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] v);
      logic [47:0] r;
      r = '0;
      for (int i = 1; i <= 48; i++) begin
         r[6'(48 - i)] = v[6'(56 - PC2_TAB[6'(i - 1)])];
      end
      return r;
   endfunction

   // Round n shifts by 1 for n in {1,2,9,16}, otherwise by 2
   function automatic logic shift_two(input logic [4:0] n);
      return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
   endfunction

   // C and D halves rotate independently
   function automatic logic [55:0] rotl(input logic [55:0] v, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = v[55:28];
      d = v[27:0];
      if (two) begin
         c = {c[25:0], c[27:26]};
         d = {d[25:0], d[27:26]};
      end else begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      return {c, d};
   endfunction

   function automatic logic [55:0] rotr(input logic [55:0] v, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = v[55:28];
      d = v[27:0];
      if (two) begin
         c = {c[1:0], c[27:2]};
         d = {d[1:0], d[27:2]};
      end else begin
         c = {c[0], c[27:1]};
         d = {d[0], d[27:1]};
      end
      return {c, d};
   endfunction

   state_t       state;
   logic [55:0]  cd;
   logic [55:0]  base;
   logic         mode;       // 1 = decrypt order
   logic [3:0]   beat;
   logic         o_valid;
   logic [47:0]  o_key;
   logic [3:0]   o_round;
   logic         o_last;

   logic [55:0]  load_src;
   logic [55:0]  load_cd;
   logic [55:0]  cd_next;
   logic [3:0]   gen_round;
   logic         advance;

   // New key wins over restart; restart replays the stored PC-1 result.
   // Encrypt starts at C1D1, decrypt at C16D16 which equals C0D0.
   assign load_src  = key_valid ? pc1(key_in) : base;
   assign load_cd   = decrypt ? load_src : rotl(load_src, 1'b0);
   assign cd_next   = mode ? rotr(cd, shift_two(5'd16 - 5'(beat)))
                           : rotl(cd, shift_two(5'(beat) + 5'd2));
   assign gen_round = mode ? (4'd15 - beat) : beat;

   // GEN steps when the beat leaves the block (direct) or the register can take it
   assign advance = (state == GEN) &&
                    ((OUT_REG != 0) ? (!o_valid || subkey_ready) : subkey_ready);

   // Schedule FSM, C/D working state and optional output register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         cd      <= '0;
         base    <= '0;
         mode    <= 1'b0;
         beat    <= '0;
         o_valid <= 1'b0;
         o_key   <= '0;
         o_round <= '0;
         o_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_valid || restart) begin
                  base  <= load_src;
                  mode  <= decrypt;
                  beat  <= '0;
                  cd    <= load_cd;
                  state <= GEN;
               end
            end
            GEN: begin
               if (advance) begin
                  cd   <= cd_next;
                  beat <= beat + 4'd1;
                  if (beat == 4'd15) begin
                     // with the register, the final beat is still waiting in it
                     state <= (OUT_REG != 0) ? DRAIN : IDLE;
                  end
               end
            end
            DRAIN: begin
               if (o_valid && subkey_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (OUT_REG != 0) begin
            if (advance) begin
               o_valid <= 1'b1;
               o_key   <= pc2(cd);
               o_round <= gen_round;
               o_last  <= (beat == 4'd15);
            end else if (o_valid && subkey_ready) begin
               o_valid <= 1'b0;
            end
         end
      end
   end

   assign key_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign subkey_valid = (OUT_REG != 0) ? o_valid : (state == GEN);
   assign subkey       = (OUT_REG != 0) ? o_key : pc2(cd);
   assign subkey_round = ROUND_W'((OUT_REG != 0) ? o_round : gen_round);
   assign subkey_last  = (OUT_REG != 0) ? o_last : (beat == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: one instance per OUT_REG setting, driven in turn
// with directed keys against the published K1..K16 of 0x133457799BBCDFF1.
module tb_des_key_schedule;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;

   logic        key_valid    [2];
   logic        restart      [2];
   logic        decrypt      [2];
   logic [63:0] key_in       [2];
   logic        subkey_ready [2];
   logic        kready       [2];
   logic        skv          [2];
   logic [47:0] sk           [2];
   logic [3:0]  sround       [2];
   logic        slast        [2];
   logic        sbusy        [2];

   logic [47:0] kexp [16];

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;

   // clock
   always #5 Clk = ~Clk;

   des_key_schedule #(.OUT_REG(0), .ROUND_W(4)) u_dut0 (
      .Clk(Clk), .Reset_n(Reset_n),
      .key_valid(key_valid[0]), .key_ready(kready[0]), .key_in(key_in[0]),
      .decrypt(decrypt[0]), .restart(restart[0]),
      .subkey_valid(skv[0]), .subkey_ready(subkey_ready[0]), .subkey(sk[0]),
      .subkey_round(sround[0]), .subkey_last(slast[0]), .busy(sbusy[0]));

   des_key_schedule #(.OUT_REG(1), .ROUND_W(4)) u_dut1 (
      .Clk(Clk), .Reset_n(Reset_n),
      .key_valid(key_valid[1]), .key_ready(kready[1]), .key_in(key_in[1]),
      .decrypt(decrypt[1]), .restart(restart[1]),
      .subkey_valid(skv[1]), .subkey_ready(subkey_ready[1]), .subkey(sk[1]),
      .subkey_round(sround[1]), .subkey_last(slast[1]), .busy(sbusy[1]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a key and/or restart while idle; checks acceptance and first-beat latency
   task automatic load(input int u, input logic [63:0] k, input logic dec,
                       input logic kv, input logic rs);
      int t;
      t = 0;
      subkey_ready[u] = 1'b0;
      @(negedge Clk);
      while (!kready[u] && t < 100) begin
         @(negedge Clk);
         t++;
      end
      check($sformatf("u%0d key_ready before load", u), 64'(kready[u]), 64'd1);
      key_valid[u] = kv;
      restart[u]   = rs;
      key_in[u]    = k;
      decrypt[u]   = dec;
      @(negedge Clk);
      key_valid[u] = 1'b0;
      restart[u]   = 1'b0;
      key_in[u]    = 64'hDEADBEEFCAFEF00D;
      check($sformatf("u%0d busy after load", u), 64'(sbusy[u]), 64'd1);
      check($sformatf("u%0d key_ready after load", u), 64'(kready[u]), 64'd0);
      check($sformatf("u%0d valid one cycle after load", u), 64'(skv[u]),
            (u == 0) ? 64'd1 : 64'd0);
      if (u == 1) begin
         @(negedge Clk);
         check($sformatf("u%0d valid two cycles after load", u), 64'(skv[u]), 64'd1);
      end
   endtask

   // Collect nbeats beats with stall_pct percent of cycles stalled
   task automatic run_sched(input int u, input logic dec, input logic zero,
                            input int stall_pct, input int nbeats);
      int          got;
      int          cyc;
      int          first_cyc;
      int          last_cyc;
      int          e;
      logic        rdy;
      logic        held;
      logic [47:0] hk;
      logic [3:0]  hr;
      logic        hl;
      logic [47:0] ek;
      got = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
      held = 1'b0; hk = '0; hr = '0; hl = 1'b0;
      while (got < nbeats && cyc < 400) begin
         rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
         if (skv[u]) begin
            if (held) begin
               check($sformatf("u%0d stall subkey", u), 64'(sk[u]), 64'(hk));
               check($sformatf("u%0d stall round", u), 64'(sround[u]), 64'(hr));
               check($sformatf("u%0d stall last", u), 64'(slast[u]), 64'(hl));
            end
            if (rdy) begin
               e  = dec ? (15 - got) : got;
               ek = zero ? 48'h0 : kexp[e];
               check($sformatf("u%0d beat %0d subkey", u, got), 64'(sk[u]), 64'(ek));
               check($sformatf("u%0d beat %0d round", u, got), 64'(sround[u]), 64'(e));
               check($sformatf("u%0d beat %0d last", u, got), 64'(slast[u]),
                     (got == 15) ? 64'd1 : 64'd0);
               if (got == 0) first_cyc = cyc;
               last_cyc = cyc;
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hk = sk[u];
               hr = sround[u];
               hl = slast[u];
            end
         end
         subkey_ready[u] = rdy;
         @(negedge Clk);
         cyc++;
      end
      subkey_ready[u] = 1'b0;
      check($sformatf("u%0d beats received", u), 64'(got), 64'(nbeats));
      if (stall_pct == 0 && nbeats == 16) begin
         check($sformatf("u%0d back-to-back span", u), 64'(last_cyc - first_cyc), 64'd15);
      end
      if (nbeats == 16) begin
         check($sformatf("u%0d valid after schedule", u), 64'(skv[u]), 64'd0);
         check($sformatf("u%0d key_ready after schedule", u), 64'(kready[u]), 64'd1);
         check($sformatf("u%0d busy after schedule", u), 64'(sbusy[u]), 64'd0);
      end
   endtask

   initial begin
      kexp[0]  = 48'h1B02EFFC7072;
      kexp[1]  = 48'h79AED9DBC9E5;
      kexp[2]  = 48'h55FC8A42CF99;
      kexp[3]  = 48'h72ADD6DB351D;
      kexp[4]  = 48'h7CEC07EB53A8;
      kexp[5]  = 48'h63A53E507B2F;
      kexp[6]  = 48'hEC84B7F618BC;
      kexp[7]  = 48'hF78A3AC13BFB;
      kexp[8]  = 48'hE0DBEBEDE781;
      kexp[9]  = 48'hB1F347BA464F;
      kexp[10] = 48'h215FD3DED386;
      kexp[11] = 48'h7571F59467E9;
      kexp[12] = 48'h97C5D1FABA41;
      kexp[13] = 48'h5F43B7F2E73A;
      kexp[14] = 48'hBF918D3D3F0A;
      kexp[15] = 48'hCB3D8B0E17F5;

      for (int u = 0; u < 2; u++) begin
         key_valid[u] = 1'b0;
         restart[u] = 1'b0;
         decrypt[u] = 1'b0;
         key_in[u] = '0;
         subkey_ready[u] = 1'b0;
      end

      // reset state
      repeat (3) @(negedge Clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset key_ready", u), 64'(kready[u]), 64'd1);
         check($sformatf("u%0d reset valid", u), 64'(skv[u]), 64'd0);
         check($sformatf("u%0d reset busy", u), 64'(sbusy[u]), 64'd0);
         check($sformatf("u%0d reset subkey", u), 64'(sk[u]), 64'd0);
      end
      Reset_n = 1'b1;

      for (int u = 0; u < 2; u++) begin
         // encrypt and decrypt, full rate
         load(u, KEY_A, 1'b0, 1'b1, 1'b0);
         run_sched(u, 1'b0, 1'b0, 0, 16);
         load(u, KEY_A, 1'b1, 1'b1, 1'b0);
         run_sched(u, 1'b1, 1'b0, 0, 16);
         // random backpressure
         load(u, KEY_A, 1'b0, 1'b1, 1'b0);
         run_sched(u, 1'b0, 1'b0, 40, 16);
         // replay stored key in decrypt order
         load(u, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b1);
         run_sched(u, 1'b1, 1'b0, 40, 16);
         // key and restart together: the new (zero) key is used
         load(u, 64'h0, 1'b0, 1'b1, 1'b1);
         run_sched(u, 1'b0, 1'b1, 20, 16);
         // parity bits ignored
         load(u, KEY_B, 1'b0, 1'b1, 1'b0);
         run_sched(u, 1'b0, 1'b0, 25, 16);
         load(u, KEY_B, 1'b1, 1'b1, 1'b0);
         run_sched(u, 1'b1, 1'b0, 25, 16);

         // reset while stalled on beat 7
         load(u, KEY_A, 1'b0, 1'b1, 1'b0);
         run_sched(u, 1'b0, 1'b0, 30, 7);
         check($sformatf("u%0d stalled beat 7 valid", u), 64'(skv[u]), 64'd1);
         check($sformatf("u%0d stalled beat 7 subkey", u), 64'(sk[u]), 64'(kexp[7]));
         #2 Reset_n = 1'b0;
         #1;
         check($sformatf("u%0d async reset valid", u), 64'(skv[u]), 64'd0);
         check($sformatf("u%0d async reset subkey", u), 64'(sk[u]), 64'd0);
         check($sformatf("u%0d async reset round", u), 64'(sround[u]), 64'd0);
         check($sformatf("u%0d async reset last", u), 64'(slast[u]), 64'd0);
         check($sformatf("u%0d async reset busy", u), 64'(sbusy[u]), 64'd0);
         check($sformatf("u%0d async reset key_ready", u), 64'(kready[u]), 64'd1);
         repeat (2) @(negedge Clk);
         Reset_n = 1'b1;
         // restart after reset replays base = 0
         load(u, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1);
         run_sched(u, 1'b0, 1'b1, 0, 16);
         // zero key gives zero subkeys
         load(u, 64'h0, 1'b1, 1'b1, 1'b0);
         run_sched(u, 1'b1, 1'b1, 30, 16);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator that replaces the standalone combinational PC-2 stage in the cipher datapath.
- Accepts a 64-bit key over a valid/ready handshake and applies PC-1.
- Streams the 16 48-bit round subkeys, one per accepted output beat, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Keeps the PC-1 result so the same key can be replayed in either mode without reloading; sits between the key register file and the Feistel round engine.

Parameters:
- OUT_REG, 0: 1 = subkey outputs driven from a pipeline register, costing one extra cycle of latency; 0 = outputs taken combinationally from the C/D state through PC-2.
- ROUND_W, 4: width of subkey_round; fixed at 4 for 16 rounds, any other value is illegal.

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- key_valid  in  1  key_in is valid
- key_ready  out  1  block can accept a key
- key_in  in  64  DES key; FIPS bit n is key_in[64-n], parity bits ignored
- decrypt  in  1  sampled on key or restart acceptance; 1 = K16..K1 order
- restart  in  1  pulse; replays the stored key using the current decrypt value
- subkey_valid  out  1  subkey is valid
- subkey_ready  in  1  downstream accepts the subkey
- subkey  out  48  round subkey; FIPS bit n is subkey[48-n]
- subkey_round  out  4  index of the emitted subkey, 0..15 = K1..K16
- subkey_last  out  1  high with the 16th beat of a schedule
- busy  out  1  high while a schedule is in progress

Behaviour:
- Bit numbering: FIPS bit n of a W-bit vector maps to vector bit [W-n]; PC-1 and PC-2 tables follow FIPS 46-3. The PC-2 mapping is reused as-is.
- Registers:
  - cd: 56-bit working C/D state, C = cd[55:28], D = cd[27:0].
  - base: 56-bit stored PC-1 result.
  - mode, beat (4-bit counter), and the FSM state.
- Shift schedule: shift(n) = 1 for n in {1, 2, 9, 16}, otherwise 2. Each half rotates independently.
- FSM states: IDLE, GEN; when OUT_REG=1, also DRAIN.
- IDLE:
  - key_ready=1, busy=0, subkey_valid=0.
  - On key_valid (key_ready is 1): base <= PC1(key_in); mode <= decrypt; beat <= 0; cd <= rotl1(PC1) if encrypt, else PC1 unrotated (C16D16 = C0D0); go to GEN.
  - Else on restart: same load, using base as the source.
  - key_valid and restart in the same cycle: the key wins and restart is ignored.
- GEN:
  - key_ready=0, busy=1. restart and key_valid are ignored.
  - Output stage (OUT_REG=0) presents subkey = PC2(cd), subkey_round = beat if encrypt else 15-beat, subkey_last = (beat==15).
  - On an accepted output transfer, the next cd is:
    - encrypt: rotl(cd, shift(beat+2));
    - decrypt: rotr(cd, shift(16-beat)).
  - Each accepted transfer increments beat. After the transfer with beat==15, go to IDLE, or to DRAIN when OUT_REG=1 and the output register is still full.
- OUT_REG=1 output stage:
  - One-entry pipeline register. GEN advances when the register is empty or subkey_ready=1.
  - The register loads on each advance and clears when a beat is accepted with nothing new loaded.
  - DRAIN holds until the final beat is accepted, then goes to IDLE.
  - key_ready is 0 in DRAIN.
- Latency:
  - Key accepted at edge t gives subkey_valid=1 in cycle t+1 (OUT_REG=0) or t+2 (OUT_REG=1).
  - With subkey_ready held high: one subkey per cycle, 16 consecutive beats.
  - The next key can be accepted in the cycle after the last beat is accepted.
- Backpressure: while subkey_valid=1 and subkey_ready=0, subkey, subkey_round and subkey_last hold stable; cd and beat do not change.
- Reset, including assertion mid-schedule:
  - Immediately: state IDLE; cd, base, mode, beat and the output register all 0.
  - Outputs: subkey_valid=0, subkey=0, subkey_round=0, subkey_last=0, busy=0, key_ready=1.
  - A schedule interrupted by reset is not resumed; restart after reset replays base=0.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, subkey_ready=1 → 16 beats on consecutive cycles; K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5; subkey_last only on round 15.
- Decrypt with the same key → first beat 0xCB3D8B0E17F5 (subkey_round=15), last beat 0x1B02EFFC7072 (subkey_round=0, subkey_last=1); every beat equals the encrypt sequence reversed.
- Randomised subkey_ready stalls in both OUT_REG settings → outputs stable during stalls; sequence matches the golden model; no beat dropped or duplicated.
- After a schedule, restart with decrypt=1 and key_valid=0 → replays K16..K1 of the stored key. key_valid and restart together → the new key is used.
- Reset_n low at beat 7 while stalled → outputs drop to reset values asynchronously. After release, a new key 0x0000000000000000 yields all-zero subkeys.
- Parity-bit independence: keys 0x133457799BBCDFF1 and 0x123456789ABCDEF0 (LSBs of every byte differ only where parity sits) → a key pair differing only in bit positions 8, 16, ..., 64 produces identical subkeys.
